// File: rtl/median_serial_sched_pkg.sv
// median_pkg: shared FSM state type and majority truth table for the serial median engine.
package median_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam logic [0:7] MAJ_TABLE = 8'b0001_0111;
endpackage

// File: rtl/median_serial_sched_arb.sv
// rr_arbiter: one-hot grant to the first requester at or after ptr, wrapping, plus its index.
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IDW  = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  id
);
    logic            found;
    logic [NREQ-1:0] cand;
    int              idx;
    always_comb begin
        grant = '0;
        id    = '0;
        found = 1'b0;
        cand  = '0;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx  = (int'(ptr) + k) % NREQ;
            cand = NREQ'(1) << idx;
            if (!found && |(req & cand)) begin
                found = 1'b1;
                grant = cand;
                id    = IDW'(idx);
            end
        end
    end
endmodule

// File: rtl/mux_8_1.sv
// mux_8_1: eight-input single-bit multiplexer, d[sel] with d indexed 0..7.
module mux_8_1 (
    input  logic [0:7] d,
    input  logic [2:0] sel,
    output logic       y
);
    assign y = d[sel];
endmodule

// File: rtl/median_serial_sched.sv
// median_serial_sched: round-robin shared bit-serial bitwise majority-of-three engine.
module median_serial_sched
    import median_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int NREQ  = 2,
    localparam int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ*WIDTH-1:0] req_c,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [IDW-1:0]        out_id,
    output logic                  busy
);
    localparam int CW = $clog2(WIDTH + 1);
    state_t            state, state_nxt;
    logic [NREQ-1:0]   grant;
    logic [IDW-1:0]    gid, ptr, id_q;
    logic [WIDTH-1:0]  sa, sb, sc, res;
    logic [CW-1:0]     cnt;
    logic              bit_y, fire, last;

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .req(req_valid), .ptr(ptr), .grant(grant), .id(gid)
    );

    mux_8_1 u_mux (.d(MAJ_TABLE), .sel({sa[0], sb[0], sc[0]}), .y(bit_y));

    // reset gates the grant so nothing looks accepted while the engine is held
    assign req_ready = (state == IDLE && rst_n) ? grant : '0;
    assign fire      = |req_ready;
    assign last      = cnt == CW'(WIDTH - 1);
    assign out_valid = state == DONE;
    assign busy      = state != IDLE;
    assign out_data  = res;
    assign out_id    = id_q;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;

    always_comb begin
        state_nxt = state;
        state_nxt = state == IDLE ? (fire ? RUN : IDLE)
                  : state == RUN  ? (last ? DONE : RUN)
                  : (out_ready ? IDLE : DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa   <= '0;
            sb   <= '0;
            sc   <= '0;
            res  <= '0;
            cnt  <= '0;
            ptr  <= '0;
            id_q <= '0;
        end else if (fire) begin
            sa   <= WIDTH'(req_a >> (int'(gid) * WIDTH));
            sb   <= WIDTH'(req_b >> (int'(gid) * WIDTH));
            sc   <= WIDTH'(req_c >> (int'(gid) * WIDTH));
            id_q <= gid;
            cnt  <= '0;
            ptr  <= (gid == IDW'(NREQ - 1)) ? '0 : gid + 1'b1;
        end else if (state == RUN) begin
            res <= {bit_y, res[WIDTH-1:1]};
            sa  <= sa >> 1;
            sb  <= sb >> 1;
            sc  <= sc >> 1;
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_median_serial_sched.sv
// tb_median_serial_sched: vector table, random ops against a majority model, and
// hand-written arbitration, backpressure, reset-abort and idle sequences.
module tb_median_serial_sched;
    localparam int W = 8;
    localparam int N = 2;
    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a = '0, req_b = '0, req_c = '0;
    logic           out_valid, busy;
    logic           out_ready = 1'b1;
    logic [W-1:0]   out_data;
    logic [0:0]     out_id;
    int             total = 0, passed = 0, cyc = 0;

    median_serial_sched #(.WIDTH(W), .NREQ(N)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_c(req_c), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_id(out_id), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(negedge clk) cyc++;

    typedef struct {int r; logic [7:0] a, b, c, exp;} vec_t;
    vec_t tbl[5];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic logic [7:0] maj(input logic [7:0] a, b, c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    task automatic set_ops(input int r, input logic [7:0] a, b, c);
        req_a[r*W +: W] = a;
        req_b[r*W +: W] = b;
        req_c[r*W +: W] = c;
    endtask

    // caller is positioned at a negedge; returns at the negedge after the output handshake
    task automatic op(input int r, input logic [7:0] a, b, c, exp, input string nm);
        int n;
        req_valid    = '0;
        req_valid[r] = 1'b1;
        set_ops(r, a, b, c);
        #1;
        n = 0;
        while (!req_ready[r] && n < 30) begin @(negedge clk); #1; n++; end
        check({nm, "_grant"}, 32'(req_ready), 32'(1 << r));
        @(negedge clk);
        req_valid = '0;
        set_ops(r, 8'($urandom), 8'($urandom), 8'($urandom));
        n = 1;
        while (!out_valid && n < 40) begin @(negedge clk); n++; end
        check({nm, "_latency"}, 32'(n), 32'(W + 1));
        check({nm, "_data"}, 32'(out_data), 32'(exp));
        check({nm, "_id"}, 32'(out_id), 32'(r));
        @(negedge clk);
        check({nm, "_released"}, 32'({busy, out_valid}), 32'(0));
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] ra, rb, rc, ops[2][3], hold_d;
        int r, n, exp_id, last_cyc;
        tbl[0] = '{0, 8'hF0, 8'hCC, 8'hAA, 8'hE8};
        tbl[1] = '{1, 8'h5A, 8'h5A, 8'hFF, 8'h5A};
        tbl[2] = '{0, 8'h00, 8'hFF, 8'h00, 8'h00};
        tbl[3] = '{1, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        tbl[4] = '{0, 8'h3C, 8'hC3, 8'h0F, 8'h0F};

        req_valid = 2'b11;
        @(negedge clk);
        #1;
        check("reset_state", 32'({req_ready, out_valid, out_data, out_id, busy}), 32'(0));
        req_valid = '0;
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++)
            op(tbl[i].r, tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].exp, $sformatf("vec%0d", i));

        for (int i = 0; i < 20; i++) begin
            r  = int'($urandom_range(0, N - 1));
            ra = 8'($urandom); rb = 8'($urandom); rc = 8'($urandom);
            op(r, ra, rb, rc, maj(ra, rb, rc), $sformatf("rand%0d", i));
        end

        pulse_reset();
        for (int q = 0; q < 2; q++)
            for (int k = 0; k < 3; k++) ops[q][k] = 8'($urandom);
        for (int q = 0; q < 2; q++) set_ops(q, ops[q][0], ops[q][1], ops[q][2]);
        req_valid = 2'b11;
        exp_id = 0;
        last_cyc = 0;
        for (int g = 0; g < 4; g++) begin
            #1;
            n = 0;
            while (req_ready == '0 && n < 30) begin @(negedge clk); #1; n++; end
            check($sformatf("rr_grant%0d", g), 32'(req_ready), 32'(1 << exp_id));
            if (g > 0) check($sformatf("rr_gap%0d", g), 32'(cyc - last_cyc), 32'(W + 2));
            last_cyc = cyc;
            n = 0;
            @(negedge clk);
            while (!out_valid && n < 40) begin @(negedge clk); n++; end
            check($sformatf("rr_data%0d", g), 32'(out_data),
                  32'(maj(ops[exp_id][0], ops[exp_id][1], ops[exp_id][2])));
            check($sformatf("rr_id%0d", g), 32'(out_id), 32'(exp_id));
            exp_id = (exp_id + 1) % N;
        end
        req_valid = '0;
        @(negedge clk);
        @(negedge clk);

        out_ready = 1'b0;
        req_valid = 2'b01;
        set_ops(0, 8'h96, 8'h69, 8'hF0);
        set_ops(1, 8'h11, 8'h22, 8'h33);
        #1;
        n = 0;
        while (!req_ready[0] && n < 30) begin @(negedge clk); #1; n++; end
        @(negedge clk);
        req_valid = 2'b11;
        n = 0;
        while (!out_valid && n < 40) begin @(negedge clk); n++; end
        hold_d = maj(8'h96, 8'h69, 8'hF0);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp_hold%0d", i),
                  32'({out_valid, req_ready, out_id, out_data}), 32'({1'b1, 2'b00, 1'b0, hold_d}));
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        #1;
        check("bp_idle", 32'({busy, out_valid, req_ready}), 32'({1'b0, 1'b0, 2'b10}));
        req_valid = '0;
        @(negedge clk);

        req_valid = 2'b10;
        set_ops(1, 8'hFF, 8'hFF, 8'hFF);
        #1;
        n = 0;
        while (!req_ready[1] && n < 30) begin @(negedge clk); #1; n++; end
        @(negedge clk);
        for (int i = 0; i < 3; i++) @(negedge clk);
        check("abort_running", 32'({busy, out_id}), 32'({1'b1, 1'b1}));
        req_valid = 2'b11;
        rst_n = 1'b0;
        #1;
        check("abort_reset", 32'({req_ready, out_valid, out_data, out_id, busy}), 32'(0));
        @(negedge clk);
        req_valid = '0;
        rst_n = 1'b1;
        @(negedge clk);
        op(1, 8'hA5, 8'h0F, 8'hF0, maj(8'hA5, 8'h0F, 8'hF0), "after_abort");

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check($sformatf("idle%0d", i), 32'({busy, out_valid, req_ready}), 32'(0));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
